// File: rtl/power_sched_pkg.sv
// Shared definitions for the power scheduler: state codes, component indices,
// default costs and the load-from-enables helper.
package power_sched_pkg;

    typedef enum logic [1:0] {
        S_OFF     = 2'b00,
        S_STARTUP = 2'b01,
        S_RUN     = 2'b10,
        S_SHED    = 2'b11
    } state_t;

    localparam int IDX_AIRFLOW   = 0;
    localparam int IDX_THRUSTERS = 1;
    localparam int IDX_SOLAR     = 2;

    localparam logic [7:0] DEF_COST_AIR = 8'd40;
    localparam logic [7:0] DEF_COST_THR = 8'd60;
    localparam int unsigned DEF_STAGGER = 4;

    // Solar costs nothing, so only airflow and thrusters contribute.
    function automatic logic [8:0] en_load(input logic [2:0] e,
                                           input logic [7:0] cost_air,
                                           input logic [7:0] cost_thr);
        logic [8:0] sum;
        sum = 9'd0;
        if (e[IDX_AIRFLOW])   sum = sum + {1'b0, cost_air};
        if (e[IDX_THRUSTERS]) sum = sum + {1'b0, cost_thr};
        return sum;
    endfunction

endpackage

// File: rtl/power_sched_stagger_timer.sv
// Saturating 4-bit cycle counter; done flags the edge at which the count
// reaches STAGGER so the caller can act on that same edge.
module stagger_timer
    import power_sched_pkg::*;
#(
    parameter int unsigned STAGGER = DEF_STAGGER
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic done
);

    localparam logic [3:0] LIMIT = 4'(STAGGER);

    logic [3:0] cnt;

    assign done = inc && (cnt >= LIMIT - 4'd1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= 4'd0;
        end else if (inc && (cnt != LIMIT)) begin
            cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: rtl/power_sched.sv
// Power-budget scheduler: staggered start-up, priority shedding, hysteretic re-admit.
// Optional macro POWER_SCHED_ALERT_PRIO_EN gives airflow priority while alert is high.
module power_sched
    import power_sched_pkg::*;
#(
    parameter logic [7:0]  COST_AIR = DEF_COST_AIR,
    parameter logic [7:0]  COST_THR = DEF_COST_THR,
    parameter int unsigned STAGGER  = DEF_STAGGER
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] power,
    input  logic       alert,
    output logic [2:0] en,
    output logic       comp_rst,
    output logic [1:0] state,
    output logic [8:0] load
);

    state_t     cur, state_next;
    logic [2:0] en_next;
    logic       stage, stage_next;
    logic [9:0] avail, need_air, need_thr;
    logic       deficit, cand_valid, cand_ok, cand_thr, shed_air_ok;
    logic       stag_inc, stag_clr, stag_done;
    logic       hyst_inc, hyst_clr, hyst_done;

    // 10-bit sums so load+cost can never wrap against the 8-bit power.
    assign avail    = {2'b00, power};
    assign need_air = {1'b0, load} + {2'b00, COST_AIR};
    assign need_thr = {1'b0, load} + {2'b00, COST_THR};
    assign deficit  = avail < {1'b0, load};
    assign state    = cur;

`ifdef POWER_SCHED_ALERT_PRIO_EN
    assign shed_air_ok = !alert;
`else
    logic unused_alert;
    assign unused_alert = alert;
    assign shed_air_ok  = 1'b1;
`endif

    always_comb begin
        cand_valid = 1'b0;
        cand_ok    = 1'b0;
        cand_thr   = 1'b0;
        if (!en[IDX_AIRFLOW]) begin
            cand_valid = 1'b1;
            cand_ok    = avail >= need_air;
        end else if (!en[IDX_THRUSTERS]) begin
            cand_valid = 1'b1;
            cand_thr   = 1'b1;
            cand_ok    = avail >= need_thr;
        end
`ifdef POWER_SCHED_ALERT_PRIO_EN
        if (alert && cand_thr) cand_valid = 1'b0;
`endif
    end

    assign stag_inc = start && (cur == S_STARTUP);
    assign stag_clr = !stag_inc || stag_done;
    assign hyst_inc = start && (cur == S_RUN) && !deficit && cand_valid && cand_ok;
    assign hyst_clr = !hyst_inc || hyst_done;

    stagger_timer #(.STAGGER(STAGGER)) u_stagger (
        .clk (clk), .rst (rst), .clr (stag_clr), .inc (stag_inc), .done (stag_done)
    );

    stagger_timer #(.STAGGER(STAGGER)) u_hyst (
        .clk (clk), .rst (rst), .clr (hyst_clr), .inc (hyst_inc), .done (hyst_done)
    );

    always_comb begin
        state_next = cur;
        en_next    = en;
        stage_next = stage;
        case (cur)
            S_OFF: begin
                state_next = S_STARTUP;
                en_next    = 3'b100;
                stage_next = 1'b0;
            end
            S_STARTUP: begin
                // stage 0 decides airflow, stage 1 decides thrusters then runs
                if (stag_done) begin
                    if (!stage) begin
                        if (avail >= need_air) en_next[IDX_AIRFLOW] = 1'b1;
                        stage_next = 1'b1;
                    end else begin
                        if (avail >= need_thr) en_next[IDX_THRUSTERS] = 1'b1;
                        state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (deficit) begin
                    state_next = S_SHED;
                end else if (hyst_done) begin
                    if (cand_thr) en_next[IDX_THRUSTERS] = 1'b1;
                    else          en_next[IDX_AIRFLOW]   = 1'b1;
                end
            end
            S_SHED: begin
                if (!deficit) begin
                    state_next = S_RUN;
                end else if (en[IDX_THRUSTERS]) begin
                    en_next[IDX_THRUSTERS] = 1'b0;
                end else if (en[IDX_AIRFLOW] && shed_air_ok) begin
                    en_next[IDX_AIRFLOW] = 1'b0;
                end
            end
            default: state_next = S_OFF;
        endcase
`ifdef POWER_SCHED_ALERT_PRIO_EN
        if (alert && (cur != S_OFF)) begin
            en_next[IDX_THRUSTERS] = 1'b0;
            if ((cur == S_RUN) || (cur == S_SHED)) en_next[IDX_AIRFLOW] = 1'b1;
        end
`endif
        if (!start) begin
            state_next = S_OFF;
            en_next    = 3'b000;
            stage_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur      <= S_OFF;
            en       <= 3'b000;
            load     <= 9'd0;
            comp_rst <= 1'b1;
            stage    <= 1'b0;
        end else begin
            cur      <= state_next;
            en       <= en_next;
            load     <= en_load(en_next, COST_AIR, COST_THR);
            comp_rst <= (state_next == S_OFF);
            stage    <= stage_next;
        end
    end

endmodule

// File: tb/tb_power_sched.sv
// Bench for power_sched: directed scenarios plus randomized power/start/reset
// traffic, compared every cycle against a time-based behavioural model.
module tb_power_sched;

    localparam int CA      = 40;
    localparam int CT      = 60;
    localparam int STAGGER = 4;
    localparam int M_OFF = 0, M_STARTUP = 1, M_RUN = 2, M_SHED = 3;

    logic       clk = 1'b0;
    logic       rst, start, alert;
    logic [7:0] power;
    logic [2:0] en;
    logic       comp_rst;
    logic [1:0] state;
    logic [8:0] load;

    int n_cmp = 0;
    int n_bad = 0;

    // model: component on/off flags, mode, time since start-up, affordable streak
    int m_mode = M_OFF;
    bit m_air = 0, m_thr = 0, m_sol = 0, m_crst = 1;
    int m_t = 0, m_streak = 0;

    power_sched dut (
        .clk(clk), .rst(rst), .start(start), .power(power), .alert(alert),
        .en(en), .comp_rst(comp_rst), .state(state), .load(load)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_load();
        return (m_air ? CA : 0) + (m_thr ? CT : 0);
    endfunction

    task automatic model_step(input bit r, input bit s, input int p);
        int ld, cost;
        bit has_cand;
        if (r || !s) begin
            m_mode = M_OFF; m_air = 0; m_thr = 0; m_sol = 0; m_crst = 1;
            m_t = 0; m_streak = 0;
            return;
        end
        ld = m_load();
        case (m_mode)
            M_OFF: begin
                m_mode = M_STARTUP; m_sol = 1; m_crst = 0; m_t = 0;
            end
            M_STARTUP: begin
                m_t++;
                if (m_t == STAGGER) begin
                    if (p >= ld + CA) m_air = 1;
                end else if (m_t == 2 * STAGGER) begin
                    if (p >= ld + CT) m_thr = 1;
                    m_mode = M_RUN; m_streak = 0;
                end
            end
            M_RUN: begin
                has_cand = !m_air || !m_thr;
                cost = !m_air ? CA : CT;
                if (p < ld) begin
                    m_mode = M_SHED; m_streak = 0;
                end else if (has_cand && p >= ld + cost) begin
                    m_streak++;
                    if (m_streak == STAGGER) begin
                        if (!m_air) m_air = 1; else m_thr = 1;
                        m_streak = 0;
                    end
                end else begin
                    m_streak = 0;
                end
            end
            default: begin
                m_streak = 0;
                if (p >= ld) m_mode = M_RUN;
                else if (m_thr) m_thr = 0;
                else if (m_air) m_air = 0;
            end
        endcase
    endtask

    task automatic tick(input bit r, input bit s, input logic [7:0] p);
        @(negedge clk);
        rst = r; start = s; power = p; alert = 1'($urandom_range(0, 1));
        @(posedge clk);
        model_step(r, s, int'(p));
        #1;
        chk("en", en, {m_sol, m_thr, m_air});
        chk("comp_rst", comp_rst, m_crst);
        chk("state", state, m_mode);
        chk("load", load, m_load());
    endtask

    int pw_table[6] = '{200, 30, 80, 100, 40, 0};

    initial begin
        logic [7:0] pw;
        bit s;
        rst = 1; start = 0; power = 0; alert = 0;
        tick(1, 0, 8'd0);
        tick(1, 0, 8'd0);
        chk("rst_en", en, 3'b000);
        chk("rst_crst", comp_rst, 1'b1);

        for (int i = 0; i < 9; i++) begin
            tick(0, 1, 8'd200);
            if (i == 0) chk("su_c1", en, 3'b100);
            if (i == 4) chk("su_c5", en, 3'b101);
        end
        chk("su_en", en, 3'b111);
        chk("su_load", load, 9'd100);
        chk("su_state", state, 2'd2);

        for (int i = 0; i < 3; i++) tick(0, 1, 8'd80);
        chk("shed1_en", en, 3'b101);
        chk("shed1_load", load, 9'd40);
        chk("shed1_state", state, 2'd2);

        for (int i = 0; i < 4; i++) tick(0, 1, 8'd200);
        chk("readmit_thr", en, 3'b111);

        for (int i = 0; i < 4; i++) tick(0, 1, 8'd30);
        chk("shed2_en", en, 3'b100);
        chk("shed2_load", load, 9'd0);

        tick(0, 1, 8'd200);
        tick(0, 1, 8'd30);
        for (int i = 0; i < 3; i++) tick(0, 1, 8'd200);
        chk("glitch_hold", en, 3'b100);
        tick(0, 1, 8'd200);
        chk("glitch_air", en, 3'b101);
        for (int i = 0; i < 4; i++) tick(0, 1, 8'd200);
        chk("glitch_thr", en, 3'b111);

        tick(0, 0, 8'd200);
        for (int i = 0; i < 5; i++) tick(0, 1, 8'd200);
        chk("mid_en", en, 3'b101);
        tick(1, 1, 8'd200);
        chk("midrst_en", en, 3'b000);
        chk("midrst_crst", comp_rst, 1'b1);
        chk("midrst_state", state, 2'd0);

        for (int i = 0; i < 12; i++) tick(0, 1, 8'd100);
        chk("equal_en", en, 3'b111);
        chk("equal_state", state, 2'd2);

        pw = 8'd200;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0) pw = 8'($urandom_range(0, 255));
                else pw = 8'(pw_table[$urandom_range(0, 5)]);
            end
            s = ($urandom_range(0, 49) != 0);
            tick(($urandom_range(0, 199) == 0), s, pw);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
